// File: rtl/clint_pkg.sv
// Shared CLINT definitions: register offsets, reset values, widths and decode helpers.
package clint_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned ADDR_W        = 64;
    localparam int unsigned STRB_W        = XLEN / 8;
    localparam int unsigned PRESC_W       = 16;
    localparam int unsigned MTIME_DIV_DEF = 100;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    localparam logic [XLEN-1:0] MTIMECMP_RST = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        REG_NONE,
        REG_MSIP,
        REG_MTIMECMP,
        REG_MTIME
    } reg_sel_e;

    // Only offset bits [15:3] select a register; the byte-in-word bits are ignored.
    function automatic reg_sel_e decode_reg(input logic [15:0] off);
        reg_sel_e sel;
        sel = REG_NONE;
        if (off[15:3] == MSIP_OFF[15:3])          sel = REG_MSIP;
        else if (off[15:3] == MTIMECMP_OFF[15:3]) sel = REG_MTIMECMP;
        else if (off[15:3] == MTIME_OFF[15:3])    sel = REG_MTIME;
        return sel;
    endfunction

    function automatic logic [XLEN-1:0] merge_lanes(input logic [XLEN-1:0]   cur,
                                                    input logic [XLEN-1:0]   wdata,
                                                    input logic [STRB_W-1:0] we);
        logic [XLEN-1:0] res;
        res = cur;
        for (int unsigned i = 0; i < STRB_W; i++) begin
            if (we[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_if.sv
// CLINT access bus from the data-path bridge; rdata is returned the cycle after a read.
interface clint_if;
    import clint_pkg::*;

    logic              clint_en;
    logic [STRB_W-1:0] clint_we;
    logic [ADDR_W-1:0] clint_addr;
    logic [XLEN-1:0]   clint_wdata;
    logic [XLEN-1:0]   clint_rdata;

    modport master (
        output clint_en, clint_we, clint_addr, clint_wdata,
        input  clint_rdata
    );

    modport slave (
        input  clint_en, clint_we, clint_addr, clint_wdata,
        output clint_rdata
    );
endinterface

// File: rtl/clint_tick_gen.sv
// mtime prescaler: counts 0..MTIME_DIV-1 and flags the last count; clr_i restarts it at 0.
module clint_tick_gen
    import clint_pkg::*;
#(
    parameter int unsigned MTIME_DIV = MTIME_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_c_o
);

    localparam logic [PRESC_W-1:0] LAST_CNT = PRESC_W'(MTIME_DIV - 1);

    logic [PRESC_W-1:0] cnt_q, cnt_d;

    assign tick_c_o = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + PRESC_W'(1);
        if (clr_i || tick_c_o) cnt_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_ctrl.sv
// Core-local interruptor: MSIP, MTIMECMP and MTIME registers plus timer/software interrupts.
// Define CLINT_PRESCALER_EN to advance mtime every MTIME_DIV cycles instead of every cycle.
module clint_ctrl
    import clint_pkg::*;
#(
    parameter int unsigned MTIME_DIV = MTIME_DIV_DEF
) (
    input  logic    clk,
    input  logic    rst,
    clint_if.slave  bus,
    output logic    timer_irq,
    output logic    soft_irq
);

    logic            tick_c, wr_c, rd_c, mtime_wr_c;
    reg_sel_e        sel_c;
    logic [XLEN-1:0] mtime_inc_c;
    logic [XLEN-1:0] mtime_q, mtime_d;
    logic [XLEN-1:0] mtimecmp_q, mtimecmp_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            msip_q, msip_d;
    logic            irq_q, irq_d;
    logic            unused_addr;

    assign wr_c        = bus.clint_en && (bus.clint_we != '0);
    assign rd_c        = bus.clint_en && (bus.clint_we == '0);
    assign sel_c       = decode_reg(bus.clint_addr[15:0]);
    assign mtime_wr_c  = wr_c && (sel_c == REG_MTIME);
    assign mtime_inc_c = mtime_q + XLEN'(tick_c);
    assign unused_addr = ^{bus.clint_addr[ADDR_W-1:16], bus.clint_addr[2:0]};

`ifdef CLINT_PRESCALER_EN
    clint_tick_gen #(
        .MTIME_DIV (MTIME_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (mtime_wr_c),
        .tick_c_o (tick_c)
    );
`else
    logic unused_div;
    assign tick_c     = 1'b1;
    assign unused_div = ^32'(MTIME_DIV);
`endif

    // Reads sample pre-edge state; MTIME writes merge into the already-incremented value.
    always_comb begin
        mtime_d    = mtime_inc_c;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        rdata_d    = rdata_q;
        irq_d      = (mtime_q >= mtimecmp_q);

        if (wr_c) begin
            case (sel_c)
                REG_MSIP:     if (bus.clint_we[0]) msip_d = bus.clint_wdata[0];
                REG_MTIMECMP: mtimecmp_d = merge_lanes(mtimecmp_q, bus.clint_wdata, bus.clint_we);
                REG_MTIME:    mtime_d    = merge_lanes(mtime_inc_c, bus.clint_wdata, bus.clint_we);
                default:      ;
            endcase
        end

        if (rd_c) begin
            case (sel_c)
                REG_MSIP:     rdata_d = XLEN'(msip_q);
                REG_MTIMECMP: rdata_d = mtimecmp_q;
                REG_MTIME:    rdata_d = mtime_q;
                default:      rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.clint_rdata = rdata_q;
    assign timer_irq       = irq_q;
    assign soft_irq        = msip_q;

endmodule

// File: doc/clint_ctrl.md
CLINT_CTRL -- requirements
Module: clint_ctrl

Interface
REQ-001 Parameter MTIME_DIV, default 100: clk cycles per mtime increment (legal range 1..65535).
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1: reset, asynchronous, active-high.
REQ-004 Port clint_en, input, 1: access enable from the data-path bridge.
REQ-005 Port clint_we, input, 8: byte write enables; 0 = read.
REQ-006 Port clint_addr, input, 64: byte address; only bits [15:3] decoded.
REQ-007 Port clint_wdata, input, 64: write data, byte lanes per clint_we.
REQ-008 Port clint_rdata, output, 64: read data, registered.
REQ-009 Port timer_irq, output, 1: machine timer interrupt, registered.
REQ-010 Port soft_irq, output, 1: machine software interrupt.

Function
REQ-011 Register map, offsets on addr[15:0]: MSIP 0x0000 (bit 0 only, rest read 0); MTIMECMP 0x4000 (64 b); MTIME 0xBFF8 (64 b); addr[2:0] ignored.
REQ-012 Write: clint_en=1 and clint_we!=0 updates only enabled byte lanes of the addressed register at the next edge; unmapped offsets ignored.
REQ-013 Read: clint_en=1 and clint_we=0 loads clint_rdata at the next edge, so data is valid the cycle after the request; unmapped offsets return 0.
REQ-014 clint_rdata holds its last value in every cycle with no read.
REQ-015 Read and write are never both served in one cycle; a write cycle does not change clint_rdata.
REQ-016 Prescaler counts 0..MTIME_DIV-1 and wraps; mtime increments by 1 in the cycle the prescaler equals MTIME_DIV-1.
REQ-017 mtime wraps from 0xFFFF_FFFF_FFFF_FFFF to 0, with no flag.
REQ-018 MTIME write coinciding with an increment: enabled lanes take wdata, disabled lanes take the incremented value; the prescaler resets to 0.
REQ-019 A read of MTIME returns the pre-edge mtime value (the value before any increment at that edge).
REQ-020 timer_irq is registered: it equals (mtime >= mtimecmp, unsigned 64-bit) as evaluated in the previous cycle.
REQ-021 timer_irq deasserts one cycle after a MTIMECMP write makes mtimecmp > mtime.
REQ-022 soft_irq equals MSIP bit 0 combinationally from the register; it is never set by hardware.

Reset
REQ-023 Asserting rst asynchronously sets mtime=0, prescaler=0, mtimecmp=all-ones, msip=0, clint_rdata=0, timer_irq=0.
REQ-024 rst asserted mid-access aborts the access; the first request after deassertion is served normally.

Configuration
REQ-025 With macro CLINT_PRESCALER_EN defined, mtime follows REQ-016 using MTIME_DIV.
REQ-026 Without CLINT_PRESCALER_EN, no prescaler exists and mtime increments every clk cycle; MTIME_DIV is ignored and REQ-018 still applies.

Structure
REQ-027 Shared package clint_pkg holds the three register offsets, the mtimecmp reset value and the MTIME_DIV default.
REQ-028 One sub-module, clint_tick_gen, holds the prescaler and emits a 1-cycle tick pulse; it is instantiated only under CLINT_PRESCALER_EN.

Verification
REQ-029 Reset, then idle 1000 cycles with MTIME_DIV=100 -> MTIME reads 10; timer_irq=0; soft_irq=0.
REQ-030 Write MTIMECMP=20, wait until mtime=20 -> timer_irq rises exactly one cycle later; write MTIMECMP=0xFFFF -> timer_irq falls one cycle after that write.
REQ-031 Write MSIP=0xFFFF_FFFF with we=0x01 -> soft_irq=1 and MSIP reads 0x1; write 0 -> soft_irq=0.
REQ-032 Write MTIME=0xFFFF_FFFF_FFFF_FFFF with we=0xFF, then one tick -> MTIME reads 0.
REQ-033 Write MTIME with we=0x0F and wdata=0x1234_5678 on a tick edge while mtime=0x1_0000_0005 -> MTIME=0x1_1234_5678; the prescaler restarts from 0.
REQ-034 Read offset 0x8000 -> rdata=0 on the next cycle; the following idle cycles hold 0; assert rst mid-read -> all outputs 0 immediately.
